rr3_mux_arbiter: RTL and testbench
==================================

RR3_MUX_ARBITER -- requirements
Module: rr3_mux_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of each requester data word and of the output word.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  3  request per source; req[0]=in1, req[1]=in2, req[2]=in3.
REQ-005 Port: in1, in2, in3  input  DATA_W each  source data words, valid while the matching req is high.
REQ-006 Port: gnt  output  3  one-hot grant, combinational; req[i]&gnt[i] at a rising edge means word i is taken.
REQ-007 Port: out_data  output  DATA_W  registered word currently presented downstream.
REQ-008 Port: out_valid  output  1  out_data holds an untransferred word.
REQ-009 Port: out_ready  input  1  downstream accepts the word when out_valid&out_ready at a rising edge.
REQ-010 Port: sel1, sel2  output  1 each  registered select code of the held source: 00=in1, 01=in2, 10=in3; 11 never driven.
REQ-011 Port: xfer_cnt  output  16  count of completed downstream transfers.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-013 An arbitration slot SHALL exist when state is IDLE, or when state is BUSY and out_ready=1.
REQ-014 In an arbitration slot with any req high, gnt SHALL be one-hot on the winner; otherwise gnt SHALL be 000.
REQ-015 gnt SHALL be 000 in BUSY while out_ready=0 (output stalled, sources held).
REQ-016 Winner SHALL be chosen round-robin: search order starts at (last+1) mod 3, then (last+2) mod 3, then last, where last is the most recently granted source.
REQ-017 On a granting edge: out_data <= winner's data, {sel1,sel2} <= winner code, last <= winner, state <= BUSY.
REQ-018 Latency: a word granted at edge N SHALL appear on out_data with out_valid=1 after edge N; earliest downstream acceptance at edge N+1.
REQ-019 BUSY with out_ready=1 and no req: state <= IDLE; out_data and sel1/sel2 SHALL retain last values.
REQ-020 BUSY with out_ready=1 and a req present: grant and reload in the same edge, staying BUSY (back-to-back, one word per cycle throughput).
REQ-021 BUSY with out_ready=0: out_data, sel1/sel2, last, state SHALL be unchanged regardless of req.
REQ-022 xfer_cnt SHALL increment by 1 at each edge with out_valid&out_ready, saturating at 16'hFFFF (no wrap).
REQ-023 A single requester SHALL be granted in every slot; with all three requesting continuously and out_ready=1 grants SHALL cycle 0,1,2,0,... with no source skipped.
REQ-024 Dropping req[i] before its grant SHALL cancel it with no state change; gnt SHALL never assert for a source whose req is low.

Reset
REQ-025 While rst_n=0 asynchronously: state=IDLE, out_valid=0, out_data=0, sel1=0, sel2=0, xfer_cnt=0, last=2 (so in1 has first priority), gnt=000.
REQ-026 Reset asserted mid-BUSY SHALL discard the held word immediately without counting it; first arbitration after release SHALL favour in1.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising edge; no grant in a cycle where rst_n=0.

Verification
REQ-028 Reset, then req=111, out_ready=1, in1=0, in2=FFFFFFFF, in3=0000FFFF -> gnt 001,010,100,001; out_data 0,FFFFFFFF,0000FFFF,0; sel1/sel2 00,01,10,00; xfer_cnt +1 per cycle.
REQ-029 req=010 only, out_ready=0 for 5 cycles after first grant -> one gnt pulse, out_data=in2 held, out_valid=1, gnt=000, xfer_cnt=0 during stall; out_ready=1 -> xfer_cnt=1, next grant in same edge.
REQ-030 Single word then req=000 -> out_valid falls after acceptance, sel1/sel2 and out_data hold, gnt=000 in IDLE.
REQ-031 Force xfer_cnt near FFFF via continuous transfers -> remains FFFF after further transfers.
REQ-032 rst_n pulsed low while BUSY with out_ready=0 -> out_valid=0, out_data=0, sel=00, xfer_cnt=0 immediately; after release req=111 -> first gnt=001.

Source files
------------

// File: rtl/rr3_mux_arbiter.sv
// rr3_mux_arbiter: three-source round-robin arbiter feeding a
// one-word registered output stage with a saturating transfer counter.
module rr3_mux_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [2:0]        gnt,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel1,
  output logic              sel2,
  output logic [15:0]       xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          code_q, code_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                slot;
  logic [2:0]          pick;
  logic [1:0]          win;

  // A slot opens when empty or when the held word leaves this edge
  assign slot = (state_q == IDLE) || out_ready;

  // Round-robin search starting after the last granted source
  always_comb begin
    pick = 3'b000;
    unique case (last_q)
      2'd0: begin
        if (req[1])      pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd1: begin
        if (req[2])      pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

  // Encode the one-hot winner into the source code
  always_comb begin
    win = 2'd0;
    unique case (1'b1)
      pick[2]: win = 2'd2;
      pick[1]: win = 2'd1;
      default: win = 2'd0;
    endcase
  end

  // No grant outside a slot or while reset is held
  assign gnt = (slot && rst_n) ? pick : 3'b000;

  // Next-state: load on grant, drain to IDLE, count transfers
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    code_d  = code_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (out_valid && out_ready && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
    if (|gnt) begin
      state_d = BUSY;
      last_d  = win;
      code_d  = win;
      unique case (win)
        2'd1:    data_d = in2;
        2'd2:    data_d = in3;
        default: data_d = in1;
      endcase
    end else if ((state_q == BUSY) && out_ready) begin
      state_d = IDLE;
    end
  end

  // State registers; reset gives in1 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      code_q  <= 2'd0;
      data_q  <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      code_q  <= code_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == BUSY);
  assign out_data  = data_q;
  assign sel1      = code_q[1];
  assign sel2      = code_q[0];
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr3_mux_arbiter.sv
// tb_rr3_mux_arbiter: directed stimulus with a scoreboard queue;
// a negedge monitor pops and compares every downstream transfer.
module tb_rr3_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [31:0] in1, in2, in3;
  logic [2:0]  gnt;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sel1, sel2;
  logic [15:0] xfer_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rr3_mux_arbiter #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel1      (sel1),
    .sel2      (sel2),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s);
    sb.push_back({d, s});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_data", out_data, e.d);
        chk("sb_sel", {30'd0, sel1, sel2}, {30'd0, e.s});
      end
    end
  end

  logic [2:0]  a_gnt [4];
  logic [31:0] a_dat [4];
  logic [1:0]  a_sel [4];

  initial begin
    a_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    a_dat = '{32'h0, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0};
    a_sel = '{2'd0, 2'd1, 2'd2, 2'd0};

    rst_n = 1'b0;
    req = 3'b111;
    in1 = '0; in2 = '0; in3 = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_sel", {30'd0, sel1, sel2}, 32'd0);
    chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("rst_gnt", {29'd0, gnt}, 32'd0);

    // Rotation with all three requesting
    step();
    rst_n = 1'b1;
    in1 = 32'h0; in2 = 32'hFFFFFFFF; in3 = 32'h0000FFFF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      chk("rr_gnt", {29'd0, gnt}, {29'd0, a_gnt[i]});
      chk("rr_cnt", {16'd0, xfer_cnt}, (i > 0) ? i - 1 : 0);
      push(a_dat[i], a_sel[i]);
    end
    step();
    req = 3'b000;
    #1;
    chk("rr_tail_gnt", {29'd0, gnt}, 32'd0);
    chk("rr_tail_valid", {31'd0, out_valid}, 32'd1);
    chk("rr_tail_cnt", {16'd0, xfer_cnt}, 32'd3);
    step();
    #1;
    chk("rr_end_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_end_cnt", {16'd0, xfer_cnt}, 32'd4);

    // Request dropped before its edge is cancelled
    step();
    req = 3'b010;
    #1;
    chk("cancel_gnt_on", {29'd0, gnt}, 32'b010);
    req = 3'b000;
    #1;
    chk("cancel_gnt_off", {29'd0, gnt}, 32'd0);
    step();
    #1;
    chk("cancel_valid", {31'd0, out_valid}, 32'd0);

    // Single word then idle: output holds
    req = 3'b100;
    in3 = 32'h12345678;
    #1;
    chk("single_gnt", {29'd0, gnt}, 32'b100);
    push(32'h12345678, 2'd2);
    step();
    req = 3'b000;
    #1;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_busy_gnt", {29'd0, gnt}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_data", out_data, 32'h12345678);
      chk("idle_sel", {30'd0, sel1, sel2}, 32'd2);
      chk("idle_gnt", {29'd0, gnt}, 32'd0);
      chk("idle_cnt", {16'd0, xfer_cnt}, 32'd5);
    end

    // Reset mid-BUSY discards the stalled word
    req = 3'b001;
    in1 = 32'hCAFEF00D;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_gnt", {29'd0, gnt}, 32'b001);
    step();
    req = 3'b000;
    #1;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_data", out_data, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_sel", {30'd0, sel1, sel2}, 32'd0);
    chk("mid_rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    req = 3'b111;
    in1 = 32'h11111111; in2 = 32'h22222222; in3 = 32'h33333333;
    out_ready = 1'b1;
    #1;
    chk("post_rst_gnt", {29'd0, gnt}, 32'b001);
    push(32'h11111111, 2'd0);
    step();
    req = 3'b000;
    step();
    #1;
    chk("post_rst_cnt", {16'd0, xfer_cnt}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Stall with a single requester
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 3'b010;
    in2 = 32'hA5A5A5A5;
    out_ready = 1'b0;
    #1;
    chk("stall_gnt0", {29'd0, gnt}, 32'b010);
    push(32'hA5A5A5A5, 2'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("stall_gnt", {29'd0, gnt}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, 32'hA5A5A5A5);
      chk("stall_cnt", {16'd0, xfer_cnt}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_gnt", {29'd0, gnt}, 32'b010);
    push(32'hA5A5A5A5, 2'd1);
    step();
    req = 3'b000;
    #1;
    chk("unstall_cnt1", {16'd0, xfer_cnt}, 32'd1);
    chk("unstall_valid", {31'd0, out_valid}, 32'd1);
    step();
    #1;
    chk("unstall_cnt2", {16'd0, xfer_cnt}, 32'd2);
    chk("unstall_idle", {31'd0, out_valid}, 32'd0);

    // Counter saturation via continuous transfers
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      if (k > 0) step();
      req = 3'b001;
      in1 = 32'(k);
      if (k == 65535) begin
        #1;
        chk("sat_fffe", {16'd0, xfer_cnt}, 32'h0000FFFE);
      end
      if (k == 65536) begin
        #1;
        chk("sat_ffff", {16'd0, xfer_cnt}, 32'h0000FFFF);
      end
      push(32'(k), 2'd0);
    end
    step();
    req = 3'b000;
    step();
    step();
    #1;
    chk("sat_hold", {16'd0, xfer_cnt}, 32'h0000FFFF);
    chk("sat_valid", {31'd0, out_valid}, 32'd0);
    chk("sat_data", out_data, 32'h00010003);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
